// File: rtl/unsigned_div_v.sv
// Sequential 8-bit / 4-bit unsigned restoring divider, one quotient bit per clock.
// Optional UNSIGNED_DIV_V_EARLY_EXIT_EN: finish in one cycle when dividend < divisor.
module unsigned_div_v (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_fu,
  input  logic [3:0] i_bu,
  output logic [7:0] o_qu,
  output logic [3:0] o_ru,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_dbz
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t     state, state_n;
  logic [7:0] dq, dq_n;
  logic [3:0] dvs, dvs_n;
  logic [4:0] prem, prem_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] qu_n;
  logic [3:0] ru_n;
  logic       dbz_n, busy_n, done_n;

  logic [5:0] shifted;
  logic [5:0] diff;
  logic       borrow;
  logic       qbit;

  // Bit 5 of the trial difference is the borrow out of the 5-bit subtract.
  assign shifted = {prem, dq[7]};
  assign diff    = shifted - {2'b00, dvs};
  assign borrow  = diff[5];
  assign qbit    = ~borrow;

  always_comb begin
    state_n = state;
    dq_n    = dq;
    dvs_n   = dvs;
    prem_n  = prem;
    cnt_n   = cnt;
    qu_n    = o_qu;
    ru_n    = o_ru;
    dbz_n   = o_dbz;
    busy_n  = o_busy;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (i_start) begin
          if (i_bu == 4'd0) begin
            qu_n    = 8'hFF;
            ru_n    = 4'hF;
            dbz_n   = 1'b1;
            done_n  = 1'b1;
            busy_n  = 1'b1;
            state_n = DONE;
          end
`ifdef UNSIGNED_DIV_V_EARLY_EXIT_EN
          else if (i_fu < {4'b0000, i_bu}) begin
            qu_n    = 8'h00;
            ru_n    = i_fu[3:0];
            dbz_n   = 1'b0;
            done_n  = 1'b1;
            busy_n  = 1'b1;
            state_n = DONE;
          end
`endif
          else begin
            dq_n    = i_fu;
            dvs_n   = i_bu;
            prem_n  = 5'd0;
            cnt_n   = 4'd0;
            busy_n  = 1'b1;
            state_n = CALC;
          end
        end
      end
      CALC: begin
        prem_n = borrow ? shifted[4:0] : diff[4:0];
        dq_n   = {dq[6:0], qbit};
        cnt_n  = cnt + 4'd1;
        if (cnt == 4'd7) begin
          qu_n    = {dq[6:0], qbit};
          ru_n    = prem_n[3:0];
          dbz_n   = 1'b0;
          done_n  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      dq     <= 8'd0;
      dvs    <= 4'd0;
      prem   <= 5'd0;
      cnt    <= 4'd0;
      o_qu   <= 8'd0;
      o_ru   <= 4'd0;
      o_dbz  <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      state  <= state_n;
      dq     <= dq_n;
      dvs    <= dvs_n;
      prem   <= prem_n;
      cnt    <= cnt_n;
      o_qu   <= qu_n;
      o_ru   <= ru_n;
      o_dbz  <= dbz_n;
      o_busy <= busy_n;
      o_done <= done_n;
    end
  end

endmodule

// File: tb/tb_unsigned_div_v.sv
// Scoreboard bench for unsigned_div_v: driver queues expectations,
// monitor checks result, latency and busy length on every done pulse.
module tb_unsigned_div_v;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] fu;
  logic [3:0] bu;
  logic [7:0] qu;
  logic [3:0] ru;
  logic       busy;
  logic       done;
  logic       dbz;

  unsigned_div_v dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_fu    (fu),
    .i_bu    (bu),
    .o_qu    (qu),
    .o_ru    (ru),
    .o_busy  (busy),
    .o_done  (done),
    .o_dbz   (dbz)
  );

  typedef struct {
    int q;
    int r;
    int dbz;
    int acc;
    int lat;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int busy_run = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks = checks + 1;
    if (got != want) begin
      failures = failures + 1;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int lat_of(input int a, input int b);
    if (b == 0) return 1;
`ifdef UNSIGNED_DIV_V_EARLY_EXIT_EN
    if (a < b) return 1;
`endif
    return 9;
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || !busy) busy_run = 0;
    else busy_run = busy_run + 1;
    if (done) begin
      if (sbq.size() == 0) begin
        checks = checks + 1;
        failures = failures + 1;
        $display("FAIL unexpected_done q=%0d r=%0d (cycle %0d)", qu, ru, cyc);
      end else begin
        e = sbq.pop_front();
        chk("quotient", int'(qu), e.q);
        chk("remainder", int'(ru), e.r);
        chk("dbz", int'(dbz), e.dbz);
        chk("latency", cyc - e.acc + 1, e.lat);
        chk("busy_len", busy_run, e.lat);
      end
    end
  end

  task automatic issue(input int a, input int b, input int q, input int r,
                       input int z, input bit expect_it);
    exp_t e;
    @(negedge clk);
    fu = 8'(a);
    bu = 4'(b);
    start = 1'b1;
    if (expect_it) begin
      e.q = q;
      e.r = r;
      e.dbz = z;
      e.acc = cyc + 1;
      e.lat = lat_of(a, b);
      sbq.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (busy || done) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL idle_timeout busy=%0d done=%0d want idle", busy, done);
    end
  endtask

  task automatic div(input int a, input int b, input int q, input int r,
                     input int z);
    issue(a, b, q, r, z, 1'b1);
    wait_idle();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_qu"}, int'(qu), 0);
    chk({tag, "_ru"}, int'(ru), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_dbz"}, int'(dbz), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fu = 8'd0;
    bu = 4'd0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    div(200, 7, 28, 4, 0);
    div(255, 15, 17, 0, 0);
    div(255, 1, 255, 0, 0);
    div(0, 5, 0, 0, 0);
    div(15, 4, 3, 3, 0);
    div(100, 0, 255, 15, 1);
    div(10, 3, 3, 1, 0);

    // Second start while busy must be ignored
    issue(200, 7, 28, 4, 0, 1'b1);
    repeat (2) @(negedge clk);
    fu = 8'd50;
    bu = 4'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    div(50, 5, 10, 0, 0);

    // Reset at the 4th CALC edge discards the division
    issue(200, 7, 0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_done_after_reset", int'(done), 0);
    div(9, 2, 4, 1, 0);

    div(9, 12, 0, 9, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout cycle=%0d want finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
